vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Programmable VGA timing generator producing the pixel counters, blanking and sync strobes that drive the pixel pipeline (background, image/ROM drawing and the sync-realignment stages downstream). Sits at the head of the video chain in the `pclk` domain. All outputs are registered and mutually aligned, so every consumer sees one consistent (hcount, vcount) coordinate per cycle. Defaults give 800x600 @ 60 Hz at a 40 MHz pixel clock.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, asserted level of hs_out
- VS_POL, 1, asserted level of vs_out
- pclk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  advance enable; counters and outputs hold while 0
- hcount  out  11  current pixel column, 0..HT-1 (HT = H_ACTIVE+H_FP+H_SYNC+H_BP = 1056)
- vcount  out  11  current line, 0..VT-1 (VT = V_ACTIVE+V_FP+V_SYNC+V_BP = 628)
- hblnk  out  1  1 while hcount >= H_ACTIVE
- vblnk  out  1  1 while vcount >= V_ACTIVE
- hs_out  out  1  HS_POL while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else !HS_POL
- vs_out  out  1  VS_POL while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else !VS_POL
- frame_start  out  1  single-cycle pulse on the first cycle of each new frame

## Operation
- Horizontal counter: on each `pclk` edge with en=1, hcount <= (hcount == HT-1) ? 0 : hcount+1.
- Vertical counter: advances only when hcount wraps (hcount == HT-1 and en=1); vcount <= (vcount == VT-1) ? 0 : vcount+1.
- Simultaneous wrap (hcount=HT-1, vcount=VT-1, en=1): both go to 0 on the same edge; frame_start is 1 in the following cycle.
- hblnk, vblnk, hs_out, vs_out are registered and computed from the *next* counter values, so in any cycle they describe exactly the hcount/vcount shown in that cycle. No skew between counters and strobes.
- en=0: all outputs hold their values; frame_start forced to 0 (the pulse never stretches).
- Counters are 11-bit unsigned; parameters must satisfy HT <= 2048 and VT <= 2048, and each porch/sync value must be >= 1. Out-of-range parameters are not supported.
- Reset (rst=0, any time, including mid-line): hcount=0, vcount=0, hblnk=0, vblnk=0, hs_out=!HS_POL, vs_out=!VS_POL, frame_start=0, frame_cnt=0. Outputs change immediately, without waiting for a clock edge. After release, the first edge with en=1 produces hcount=1. No frame_start is issued for the post-reset frame.

## Timing
- Latency from en rising to first counter change: 1 cycle.
- Line period: HT en-cycles. Frame period: HT*VT en-cycles (663168 at defaults).
- hblnk rises on the cycle hcount=800 and falls on the cycle hcount=0.
- hs_out is asserted for hcount 840..967. vs_out is asserted for vcount 601..604, spanning whole lines, and changes on the same cycle hcount becomes 0.
- Downstream stages that add N cycles of latency (ROM reads) must delay all these outputs by N. This block adds no pipeline latency of its own.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: adds output port `frame_cnt  out  16`. It resets to 0 and increments by 1, wrapping modulo 65536, on each cycle that frame_start=1. It is registered together with frame_start, so it shows the new value in the same cycle as the pulse.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset then en=1 for 1056 cycles -> hcount sweeps 0..1055 and returns to 0, vcount becomes 1 on the cycle hcount=0, hblnk=1 exactly for hcount 800..1055, hs_out=1 exactly for 840..967.
- Run a full frame (663168 cycles) -> frame_start pulses once, when hcount=0 and vcount=0; vblnk=1 for vcount 600..627; vs_out=1 for vcount 601..604; with VGA_TIMING_FRAME_CNT_EN, frame_cnt=1.
- Toggle en 0/1 every other cycle across the line end (hcount 1054..1056) -> counters advance only on en=1 edges, outputs hold on en=0, and frame_start never lasts more than 1 cycle.
- Assert rst asynchronously at hcount=500, vcount=300 between edges -> all outputs reach their reset values before the next `pclk` edge; after release the count restarts from 0,0.
- Override HS_POL=0 and VS_POL=0, with small timing values H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 -> HT=8, VT=5, hs_out=0 only at hcount 5..6, vs_out=0 only at vcount 3.
- With VGA_TIMING_FRAME_CNT_EN, force 65536 frames using the small configuration above -> frame_cnt wraps from 65535 to 0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// +----------------------------------------------------------------------+
// | vga_timing_gen_if                                                     |
// | Advance enable plus timing outputs of vga_timing_gen. The frame_cnt   |
// | member exists only when VGA_TIMING_FRAME_CNT_EN is defined.           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface vga_timing_gen_if;
    logic        en;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hs_out;
    logic        vs_out;
    logic        frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
        input  en,
        output hcount, vcount, hblnk, vblnk, hs_out, vs_out, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        output en,
        input  hcount, vcount, hblnk, vblnk, hs_out, vs_out, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +----------------------------------------------------------------------+
// | vga_timing_gen                                                        |
// | Programmable VGA pixel/line counters with blanking, sync strobes and  |
// | a frame-start pulse; optional frame counter (VGA_TIMING_FRAME_CNT_EN).|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  wire logic       pclk,
    input  wire logic       rst,
    vga_timing_gen_if.master vga
);

    localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] c_h_last     = 11'(HT - 1);
    localparam logic [10:0] c_v_last     = 11'(VT - 1);
    localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_active   = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_vs_start   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_hs;
    logic        r_vs;
    logic        r_frame_start;

    logic [10:0] w_h_next;
    logic [10:0] w_v_next;
    logic        w_h_wrap;
    logic        w_v_wrap;

    always_comb begin
        w_h_wrap = (r_hcount == c_h_last);
        w_v_wrap = (r_vcount == c_v_last);
        w_h_next = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
        w_v_next = r_vcount;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? 11'd0 : r_vcount + 11'd1;
        end
    end

    // Strobes are decoded from the next counter values so they land on the
    // same edge as the coordinates they describe.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_hs          <= !HS_POL;
            r_vs          <= !VS_POL;
            r_frame_start <= 1'b0;
        end else if (vga.en) begin
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_hblnk       <= (w_h_next >= c_h_active);
            r_vblnk       <= (w_v_next >= c_v_active);
            r_hs          <= ((w_h_next >= c_hs_start) && (w_h_next < c_hs_end)) ? HS_POL : !HS_POL;
            r_vs          <= ((w_v_next >= c_vs_start) && (w_v_next < c_vs_end)) ? VS_POL : !VS_POL;
            r_frame_start <= w_h_wrap && w_v_wrap;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign vga.hcount      = r_hcount;
    assign vga.vcount      = r_vcount;
    assign vga.hblnk       = r_hblnk;
    assign vga.vblnk       = r_vblnk;
    assign vga.hs_out      = r_hs;
    assign vga.vs_out      = r_vs;
    assign vga.frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= 16'd0;
        end else if (vga.en && w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign vga.frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// +----------------------------------------------------------------------+
// | tb_vga_timing_gen                                                     |
// | Bench for a default 800x600 instance and a tiny inverted-polarity one.|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic        hs;
        logic        vs;
        logic        fs;
    } obs_t;

    typedef struct {
        int ha, hf, hsw, hbp, va, vf, vsw, vbp;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        bit   en;
        int   n;
        obs_t e;
    } vec_t;

    logic pclk = 1'b0;
    logic rst0;
    logic rst1;
    always #5 pclk = ~pclk;

    vga_timing_gen_if vif0 ();
    vga_timing_gen_if vif1 ();

    vga_timing_gen u_d0 (
        .pclk (pclk),
        .rst  (rst0),
        .vga  (vif0)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b0), .VS_POL (1'b0)
    ) u_d1 (
        .pclk (pclk),
        .rst  (rst1),
        .vga  (vif1)
    );

    int     checks   = 0;
    int     failures = 0;
    longint t  [2];
    bit     fs [2];
    int     fc [2];
    cfg_t   cfg[2];

    // Reference: position is simply the number of enabled edges since reset.
    function automatic obs_t model(cfg_t c, longint tt, bit f);
        obs_t o;
        int ht, vt, h, v;
        ht = c.ha + c.hf + c.hsw + c.hbp;
        vt = c.va + c.vf + c.vsw + c.vbp;
        h  = int'(tt % ht);
        v  = int'((tt / ht) % vt);
        o.h  = 11'(h);
        o.v  = 11'(v);
        o.hb = (h >= c.ha);
        o.vb = (v >= c.va);
        o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hp : !c.hp;
        o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vp : !c.vp;
        o.fs = f;
        return o;
    endfunction

    function automatic longint frame_len(cfg_t c);
        return longint'(c.ha + c.hf + c.hsw + c.hbp) * longint'(c.va + c.vf + c.vsw + c.vbp);
    endfunction

    function automatic obs_t sample(int k);
        if (k == 0)
            return {vif0.hcount, vif0.vcount, vif0.hblnk, vif0.vblnk, vif0.hs_out, vif0.vs_out, vif0.frame_start};
        return {vif1.hcount, vif1.vcount, vif1.hblnk, vif1.vblnk, vif1.hs_out, vif1.vs_out, vif1.frame_start};
    endfunction

    function automatic obs_t mk(int h, int v, bit hb, bit vb, bit hs, bit vs, bit f);
        obs_t o;
        o = {11'(h), 11'(v), hb, vb, hs, vs, f};
        return o;
    endfunction

    task automatic cmp(string name, int k, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b fs=%b, expected h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b fs=%b",
                     name, k, got.h, got.v, got.hb, got.vb, got.hs, got.vs, got.fs,
                     exp.h, exp.v, exp.hb, exp.vb, exp.hs, exp.vs, exp.fs);
        end
    endtask

    task automatic check_models(string name);
        for (int k = 0; k < 2; k++) begin
            cmp(name, k, sample(k), model(cfg[k], t[k], fs[k]));
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (vif0.frame_cnt !== 16'(fc[0]) || vif1.frame_cnt !== 16'(fc[1])) begin
            failures++;
            $display("FAIL %s frame_cnt: got %0d/%0d, expected %0d/%0d",
                     name, vif0.frame_cnt, vif1.frame_cnt, fc[0], fc[1]);
        end
`endif
    endtask

    task automatic model_reset(int k);
        t[k]  = 0;
        fs[k] = 1'b0;
        fc[k] = 0;
    endtask

    // Advance one clock; the model follows the inputs seen at the edge.
    task automatic tick();
        bit r, e;
        @(posedge pclk);
        for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? rst0 : rst1;
            e = (k == 0) ? vif0.en : vif1.en;
            if (!r) begin
                model_reset(k);
            end else if (e) begin
                t[k]++;
                fs[k] = ((t[k] % frame_len(cfg[k])) == 0);
                if (fs[k]) fc[k] = (fc[k] + 1) % 65536;
            end else begin
                fs[k] = 1'b0;
            end
        end
        #1;
    endtask

    vec_t vecs[$];
    int   n_to_500;

    initial begin
        cfg[0] = '{ha: 800, hf: 40, hsw: 128, hbp: 88, va: 600, vf: 1, vsw: 4, vbp: 23, hp: 1'b1, vp: 1'b1};
        cfg[1] = '{ha: 4, hf: 1, hsw: 2, hbp: 1, va: 2, vf: 1, vsw: 1, vbp: 1, hp: 1'b0, vp: 1'b0};
        model_reset(0);
        model_reset(1);

        // Small config (HT=8, VT=5): hs low at h 5..6, vs low at v 3.
        vecs.push_back('{en: 1'b1, n: 0, e: mk(0, 0, 0, 0, 1, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 4, e: mk(4, 0, 1, 0, 1, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 1, e: mk(5, 0, 1, 0, 0, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 1, e: mk(6, 0, 1, 0, 0, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 1, e: mk(7, 0, 1, 0, 1, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 1, e: mk(0, 1, 0, 0, 1, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 8, e: mk(0, 2, 0, 1, 1, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 8, e: mk(0, 3, 0, 1, 1, 0, 0)});
        vecs.push_back('{en: 1'b1, n: 7, e: mk(7, 3, 1, 1, 1, 0, 0)});
        vecs.push_back('{en: 1'b1, n: 1, e: mk(0, 4, 0, 1, 1, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 7, e: mk(7, 4, 1, 1, 1, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 1, e: mk(0, 0, 0, 0, 1, 1, 1)});
        vecs.push_back('{en: 1'b1, n: 1, e: mk(1, 0, 0, 0, 1, 1, 0)});
        vecs.push_back('{en: 1'b0, n: 3, e: mk(1, 0, 0, 0, 1, 1, 0)});
        vecs.push_back('{en: 1'b1, n: 6, e: mk(7, 0, 1, 0, 1, 1, 0)});
        vecs.push_back('{en: 1'b0, n: 2, e: mk(7, 0, 1, 0, 1, 1, 0)});

        rst0 = 1'b0;
        rst1 = 1'b0;
        vif0.en = 1'b0;
        vif1.en = 1'b0;
        tick();
        tick();
        check_models("reset");
        rst0 = 1'b1;
        rst1 = 1'b1;

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                vif1.en = vecs[i].en;
                tick();
            end
            cmp($sformatf("vec%0d", i), 1, sample(1), vecs[i].e);
        end
        vif1.en = 1'b0;

        // Full default line, then walk up to the end of the next line.
        for (int c = 0; c < 1056 + 1053; c++) begin
            vif0.en = 1'b1;
            vif1.en = 1'($urandom_range(0, 1));
            tick();
            check_models("line_sweep");
        end

        // Alternate enable across the line end.
        for (int c = 0; c < 8; c++) begin
            vif0.en = (c % 2 == 0);
            vif1.en = (c % 2 == 0);
            tick();
            check_models("en_toggle");
        end

        for (int c = 0; c < 3000; c++) begin
            vif0.en = ($urandom_range(0, 3) != 0);
            vif1.en = ($urandom_range(0, 3) != 0);
            tick();
            check_models("random");
        end

        // Async reset mid-line, between clock edges.
        n_to_500 = (500 - int'(t[0] % 1056) + 1056) % 1056;
        for (int c = 0; c < n_to_500; c++) begin
            vif0.en = 1'b1;
            vif1.en = 1'b1;
            tick();
            check_models("to_500");
        end
        #3;
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_models("async_rst");
        tick();
        check_models("rst_hold");
        rst0 = 1'b1;
        rst1 = 1'b1;
        tick();
        check_models("post_rst");

        for (int c = 0; c < 500; c++) begin
            vif0.en = ($urandom_range(0, 4) != 0);
            vif1.en = ($urandom_range(0, 4) != 0);
            tick();
            check_models("random2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
